pc_sequencer: RTL and testbench

Parametrised program-counter sequencer that generates the instruction fetch address for the SPORK core. It extends the basic start/halt/jump counter with configurable address and offset widths, absolute and PC-relative jumps, and a hardware return-address stack for call/return. It sits between the decode/branch logic, which drives the control strobes, and instruction memory, which consumes `PC`.

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the SPORK fetch stage: start/halt control,
// absolute and PC-relative jumps, and a hardware return-address stack for call/ret.
module pc_sequencer #(
    parameter int              PC_W        = 16,
    parameter int              OFF_W       = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_ADDR  = '0,
    localparam int             CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             jump,
    input  logic             jump_rel,
    input  logic [OFF_W-1:0] jump_value,
    input  logic             call,
    input  logic             ret,
    output logic [PC_W-1:0]  PC,
    output logic             running,
    output logic [CNT_W-1:0] stack_count,
    output logic             stack_overflow,
    output logic             stack_underflow
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];
    logic [PC_W-1:0]   stack_d [STACK_DEPTH];

    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   target;
    logic              stack_full;
    logic              stack_empty;

    // Relative targets sign-extend the operand; absolute targets zero-extend it.
    always_comb begin
        pc_inc      = pc_q + PC_W'(1);
        target      = jump_rel ? (pc_q + PC_W'($signed(jump_value))) : PC_W'(jump_value);
        stack_full  = (cnt_q == CNT_W'(STACK_DEPTH));
        stack_empty = (cnt_q == '0);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_ADDR;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (ret) begin
                    if (!stack_empty) begin
                        pc_d  = stack_q[IDX_W'(cnt_q - CNT_W'(1))];
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        unf_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end else if (call) begin
                    if (!stack_full) begin
                        stack_d[IDX_W'(cnt_q)] = pc_inc;
                        pc_d  = target;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end else if (jump) begin
                    pc_d = target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            HALTED: begin
                // Resume holds PC on the start edge; increments begin on the next one.
                if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_ADDR;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage carries no reset; only the occupancy count defines valid entries.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign PC              = pc_q;
    assign running         = (state_q == RUN);
    assign stack_count     = cnt_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt;
    logic        jump;
    logic        jump_rel;
    logic [7:0]  jump_value;
    logic        call;
    logic        ret;
    logic [15:0] PC;
    logic        running;
    logic [2:0]  stack_count;
    logic        stack_overflow;
    logic        stack_underflow;

    int compared;
    int mismatched;

    pc_sequencer #(
        .PC_W(16),
        .OFF_W(8),
        .STACK_DEPTH(4),
        .RESET_ADDR(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .halt(halt),
        .jump(jump),
        .jump_rel(jump_rel),
        .jump_value(jump_value),
        .call(call),
        .ret(ret),
        .PC(PC),
        .running(running),
        .stack_count(stack_count),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of strobes, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic s, input logic h, input logic j, input logic rel,
                                 input logic [7:0] val, input logic c, input logic r);
        start      = s;
        halt       = h;
        jump       = j;
        jump_rel   = rel;
        jump_value = val;
        call       = c;
        ret        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic jumpAbs(input logic [7:0] val);
        applyStimulus(0, 0, 1, 0, val, 0, 0);
    endtask

    initial begin
        int cycles;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        start = 0; halt = 0; jump = 0; jump_rel = 0; jump_value = 0; call = 0; ret = 0;

        // Scenario 1: reset, start, count up
        @(posedge clk); #1;
        idle();
        checkOutput("rst_pc", PC, 16'h0000);
        checkOutput("rst_running", running, 0);
        checkOutput("rst_count", stack_count, 0);
        checkOutput("rst_flags", {stack_overflow, stack_underflow}, 0);
        reset = 1'b1;
        idle();
        checkOutput("idle_hold_pc", PC, 16'h0000);
        checkOutput("idle_running", running, 0);
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("start_pc", PC, 16'h0000);
        checkOutput("start_running", running, 1);
        idle();
        checkOutput("inc1", PC, 16'h0001);
        idle();
        checkOutput("inc2", PC, 16'h0002);
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("start_in_run", PC, 16'h0003);

        // Scenario 2: relative and absolute jumps
        jumpAbs(8'h10);
        checkOutput("jabs_10", PC, 16'h0010);
        applyStimulus(0, 0, 1, 1, 8'hF8, 0, 0);
        checkOutput("jrel_neg8", PC, 16'h0008);
        jumpAbs(8'h40);
        checkOutput("jabs_40", PC, 16'h0040);

        // Scenario 3: call and return
        jumpAbs(8'h05);
        applyStimulus(0, 0, 0, 0, 8'h20, 1, 0);
        checkOutput("call_pc", PC, 16'h0020);
        checkOutput("call_count", stack_count, 1);
        idle();
        idle();
        checkOutput("call_body_pc", PC, 16'h0022);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1);
        checkOutput("ret_pc", PC, 16'h0006);
        checkOutput("ret_count", stack_count, 0);

        // ret outranks call: pop happens, call is dropped without a flag
        applyStimulus(0, 0, 0, 1, 8'h10, 1, 0);
        checkOutput("relcall_pc", PC, 16'h0016);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 1);
        checkOutput("callret_pc", PC, 16'h0007);
        checkOutput("callret_count", stack_count, 0);
        checkOutput("callret_ovf", stack_overflow, 0);

        // Scenario 4: stack limits
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 8'h80, 1, 0);
        end
        checkOutput("full_count", stack_count, 4);
        checkOutput("full_ovf", stack_overflow, 1);
        checkOutput("full_pc", PC, 16'h0081);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, 0, 1);
        end
        checkOutput("pop3_pc", PC, 16'h0081);
        checkOutput("pop3_count", stack_count, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1);
        checkOutput("pop4_pc", PC, 16'h0008);
        checkOutput("pop4_count", stack_count, 0);
        checkOutput("pop4_unf", stack_underflow, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1);
        checkOutput("unf_pc", PC, 16'h0009);
        checkOutput("unf_flag", stack_underflow, 1);
        idle();
        checkOutput("sticky_flags", {stack_overflow, stack_underflow}, 2'b11);
        checkOutput("sticky_pc", PC, 16'h000A);

        // Scenario 5: halt and resume
        jumpAbs(8'h07);
        applyStimulus(0, 1, 0, 0, 8'h00, 0, 0);
        checkOutput("halt_pc", PC, 16'h0007);
        checkOutput("halt_running", running, 0);
        jumpAbs(8'h40);
        checkOutput("halt_jump_ign", PC, 16'h0007);
        applyStimulus(0, 0, 0, 0, 8'h40, 1, 0);
        checkOutput("halt_call_ign", stack_count, 0);
        checkOutput("halt_call_pc", PC, 16'h0007);
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("resume_pc", PC, 16'h0007);
        checkOutput("resume_running", running, 1);
        idle();
        checkOutput("resume_inc", PC, 16'h0008);

        // Scenario 6: wrap at 0xFFFF, then reset mid-call
        jumpAbs(8'hFF);
        checkOutput("jabs_ff", PC, 16'h00FF);
        applyStimulus(0, 0, 1, 1, 8'h7F, 0, 0);
        checkOutput("jrel_7f", PC, 16'h017E);
        cycles = 0;
        while (PC !== 16'hFFFF && cycles < 70000) begin
            idle();
            cycles++;
        end
        checkOutput("wrap_reach", PC, 16'hFFFF);
        idle();
        checkOutput("wrap_zero", PC, 16'h0000);
        applyStimulus(0, 0, 1, 1, 8'hFF, 0, 0);
        checkOutput("jrel_wrap", PC, 16'hFFFF);
        applyStimulus(0, 0, 0, 0, 8'h20, 1, 0);
        checkOutput("call_wrap_pc", PC, 16'h0020);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1);
        checkOutput("ret_wrap_pc", PC, 16'h0000);
        applyStimulus(0, 0, 0, 0, 8'h30, 1, 0);
        checkOutput("precall_count", stack_count, 1);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 8'h30, 1, 0);
        reset = 1'b1;
        checkOutput("rst2_pc", PC, 16'h0000);
        checkOutput("rst2_count", stack_count, 0);
        checkOutput("rst2_running", running, 0);
        checkOutput("rst2_flags", {stack_overflow, stack_underflow}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
